// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort sequencer: FSM state encoding and
// the pass-end index helper.
package sort_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } sort_state_t;

  // Last compare index of a pass: each pass bubbles one more element into place.
  function automatic int pass_last_idx(input int n, input int pass);
    return n - 2 - pass;
  endfunction

endpackage

// File: rtl/cas_watchdog.sv
// Cycle watchdog for a compare-and-swap sequencer: counts enabled cycles since
// the last clear and flags expiry once the count reaches TIMEOUT-1.
module cas_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = (count_reg == LIMIT);

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer driving the CAS datapath one index at a time, with
// early exit on a swap-free pass and a watchdog for a hung datapath.
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2*ADDR_WIDTH-1:0] cmp_count,
  output logic                    cas_start,
  output logic [ADDR_WIDTH:0]     cas_i,
  input  logic                    cas_finish,
  input  logic                    cas_we
);

  localparam int N = 2**ADDR_WIDTH;

  sort_state_t             state_reg, state_next;
  logic [ADDR_WIDTH:0]     pass_reg, pass_next;
  logic [ADDR_WIDTH:0]     cas_i_reg, cas_i_next;
  logic                    swapped_reg, swapped_next;
  logic [2*ADDR_WIDTH-1:0] cmp_count_reg, cmp_count_next;
  logic                    error_reg, error_next;
  logic                    busy_reg, done_reg, cas_start_reg;
  logic                    wd_clear, wd_enable, wd_expire;

  // The ISSUE and ERROR cycles take up two cycles of the TIMEOUT budget, so
  // busy drops exactly TIMEOUT cycles after the cas_start pulse.
  cas_watchdog #(
    .TIMEOUT(TIMEOUT - 2)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_next     = state_reg;
    pass_next      = pass_reg;
    cas_i_next     = cas_i_reg;
    swapped_next   = swapped_reg;
    cmp_count_next = cmp_count_reg;
    error_next     = error_reg;
    wd_clear       = 1'b0;
    wd_enable      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = ISSUE;
          pass_next      = '0;
          cas_i_next     = '0;
          swapped_next   = 1'b0;
          cmp_count_next = '0;
          error_next     = 1'b0;
        end
      end
      ISSUE: begin
        wd_clear   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        wd_enable = 1'b1;
        if (cas_we) begin
          swapped_next = 1'b1;
        end
        if (cas_finish) begin
          cmp_count_next = cmp_count_reg + 1'b1;
          state_next     = NEXT;
        end else if (wd_expire) begin
          error_next = 1'b1;
          state_next = ERROR;
        end
      end
      NEXT: begin
        if (int'(cas_i_reg) < pass_last_idx(N, int'(pass_reg))) begin
          cas_i_next = cas_i_reg + 1'b1;
          state_next = ISSUE;
        end else if (!swapped_reg || (int'(pass_reg) == N - 2)) begin
          state_next = DONE;
        end else begin
          pass_next    = pass_reg + 1'b1;
          cas_i_next   = '0;
          swapped_next = 1'b0;
          state_next   = ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pass_reg      <= '0;
      cas_i_reg     <= '0;
      swapped_reg   <= 1'b0;
      cmp_count_reg <= '0;
      error_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cas_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pass_reg      <= pass_next;
      cas_i_reg     <= cas_i_next;
      swapped_reg   <= swapped_next;
      cmp_count_reg <= cmp_count_next;
      error_reg     <= error_next;
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
      cas_start_reg <= (state_next == ISSUE);
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign cmp_count = cmp_count_reg;
  assign cas_start = cas_start_reg;
  assign cas_i     = cas_i_reg;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with a behavioural CAS unit and a
// 4-entry byte memory; one line printed per sort transaction.
module tb_bubble_sort_ctrl;

  localparam int AW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error, cas_start;
  logic [2*AW-1:0] cmp_count;
  logic [AW:0]   cas_i;
  logic          cas_finish, cas_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bubble_sort_ctrl #(
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cmp_count (cmp_count),
    .cas_start (cas_start),
    .cas_i     (cas_i),
    .cas_finish(cas_finish),
    .cas_we    (cas_we)
  );

  // Behavioural CAS unit plus memory (entries 0..3 used).
  logic [7:0]  mem [0:7];
  logic [31:0] load_vec = 32'd0;
  logic        load_req = 1'b0;
  logic        hang = 1'b0;
  logic [1:0]  cst;
  logic [7:0]  a_q, b_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cst        <= 2'd0;
      cas_finish <= 1'b0;
      cas_we     <= 1'b0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
    end else begin
      if (load_req) begin
        mem[3'd0] <= load_vec[7:0];
        mem[3'd1] <= load_vec[15:8];
        mem[3'd2] <= load_vec[23:16];
        mem[3'd3] <= load_vec[31:24];
      end
      case (cst)
        2'd0: begin
          cas_finish <= 1'b0;
          if (cas_start && !hang) cst <= 2'd1;
        end
        2'd1: begin
          a_q <= mem[cas_i];
          b_q <= mem[cas_i + 3'd1];
          if (mem[cas_i] > mem[cas_i + 3'd1]) begin
            cas_we <= 1'b1;
            cst    <= 2'd2;
          end else begin
            cas_finish <= 1'b1;
            cst        <= 2'd0;
          end
        end
        2'd2: begin
          mem[cas_i] <= b_q;
          cst        <= 2'd3;
        end
        default: begin
          mem[cas_i + 3'd1] <= a_q;
          cas_we            <= 1'b0;
          cas_finish        <= 1'b1;
          cst               <= 2'd0;
        end
      endcase
    end
  end

  int start_pulses = 0;
  always @(posedge clk) begin
    if (cas_start) start_pulses <= start_pulses + 1;
  end

  function automatic logic [31:0] mem_word();
    return {mem[3'd3], mem[3'd2], mem[3'd1], mem[3'd0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [31:0] v);
    @(negedge clk);
    load_vec = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_sort(input string tag, input logic [31:0] init,
                          input logic [31:0] exp_mem, input int exp_cmp, input bit hold);
    int p0;
    bit seen;
    load_mem(init);
    p0 = start_pulses;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_err_clr"}, 32'(error), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_cmp_count"}, 32'(cmp_count), 32'(exp_cmp));
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_cas_starts"}, 32'(start_pulses - p0), 32'(exp_cmp));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    if (hold) begin
      repeat (3) @(negedge clk);
      check_eq({tag, "_no_restart"}, 32'(start_pulses - p0), 32'(exp_cmp));
      check_eq({tag, "_cmp_hold"}, 32'(cmp_count), 32'(exp_cmp));
    end
    check_eq({tag, "_mem"}, mem_word(), exp_mem);
    $display("sort %s: cmp_count=%0d mem=%h", tag, cmp_count, mem_word());
  endtask

  initial begin
    int p0;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_cmp", 32'(cmp_count), 32'd0);
    check_eq("rst_cas_start", 32'(cas_start), 32'd0);
    check_eq("rst_cas_i", 32'(cas_i), 32'd0);
    reset_n = 1'b1;

    // mem[0] is the low byte
    run_sort("reverse", 32'h01020304, 32'h04030201, 6, 1'b0);
    run_sort("sorted",  32'h04030201, 32'h04030201, 3, 1'b0);
    run_sort("partial_hold", 32'h04030102, 32'h04030201, 5, 1'b1);

    // Hung datapath
    load_mem(32'h01020304);
    hang = 1'b1;
    p0 = start_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("hang_cas_start", 32'(cas_start), 32'd1);
    repeat (TO - 2) @(negedge clk);
    check_eq("hang_busy_tm2", 32'(busy), 32'd1);
    check_eq("hang_err_tm2", 32'(error), 32'd0);
    @(negedge clk);
    check_eq("hang_busy_tm1", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("hang_busy_t", 32'(busy), 32'd0);
    check_eq("hang_err_t", 32'(error), 32'd1);
    check_eq("hang_cmp", 32'(cmp_count), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("hang_err_sticky", 32'(error), 32'd1);
    check_eq("hang_one_start", 32'(start_pulses - p0), 32'd1);
    $display("sort hang: error=%0d busy=%0d", error, busy);
    hang = 1'b0;
    run_sort("after_error", 32'h01020304, 32'h04030201, 6, 1'b0);

    // Asynchronous reset in the middle of a WAIT
    load_mem(32'h01020304);
    p0 = start_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (start_pulses - p0 == 3) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("mid_reached", 32'(seen), 32'd1);
    check_eq("mid_cas_i", 32'(cas_i), 32'd2);
    check_eq("mid_cmp", 32'(cmp_count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_error", 32'(error), 32'd0);
    check_eq("arst_cmp", 32'(cmp_count), 32'd0);
    check_eq("arst_cas_start", 32'(cas_start), 32'd0);
    check_eq("arst_cas_i", 32'(cas_i), 32'd0);
    $display("sort mid_reset: busy=%0d cmp_count=%0d", busy, cmp_count);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_sort("reset_recovery", 32'h02040103, 32'h04030201, 6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "simulation time limit");
  end

endmodule
